// File: rtl/maze_pkg.sv
// Shared constants, types and probe-point helper for the maze tile probes.
package maze_pkg;

    localparam int unsigned TILE_SHIFT = 4;
    localparam int unsigned MAP_COLS   = 26;
    localparam int unsigned MAP_ROWS   = 28;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned PT_W       = 11;
    localparam int unsigned CODE_W     = 5;
    localparam int unsigned NUM_PROBES = 4;
    localparam int unsigned K_W        = 3;

    localparam logic [CODE_W-1:0] BLOCKED   = 5'h1F;
    localparam logic [CODE_W-1:0] TILE_OPEN = 5'd0;

    typedef enum logic [1:0] {PROBE_L, PROBE_R, PROBE_B, PROBE_T} probe_e;
    typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_e;

    // Probe coordinates are two's-complement so underflow shows up as a set sign bit
    typedef struct packed {
        logic [PT_W-1:0] px;
        logic [PT_W-1:0] py;
    } point_t;

    function automatic point_t probe_point(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y,
                                           input logic [COORD_W-1:0] s,
                                           input probe_e             p);
        logic [PT_W-1:0] xe;
        logic [PT_W-1:0] ye;
        logic [PT_W-1:0] se;
        point_t          pt;
        xe    = PT_W'(x);
        ye    = PT_W'(y);
        se    = PT_W'(s);
        pt.px = xe;
        pt.py = ye;
        case (p)
            PROBE_L: pt.px = xe - se - PT_W'(1);
            PROBE_R: pt.px = xe + se + PT_W'(1);
            PROBE_B: pt.py = ye + se + PT_W'(1);
            default: pt.py = ye - se - PT_W'(1);
        endcase
        return pt;
    endfunction

endpackage

// File: rtl/maze_probe_if.sv
// Frame/position inputs, tile-ROM port and published wall codes of the maze probe.
interface maze_probe_if;

    logic                               frame_clk;
    logic                               restart;
    logic [maze_pkg::COORD_W-1:0]       BallX;
    logic [maze_pkg::COORD_W-1:0]       BallY;
    logic [maze_pkg::COORD_W-1:0]       BallS;
    logic [maze_pkg::ADDR_W-1:0]        rom_addr;
    logic [maze_pkg::CODE_W-1:0]        rom_data;
    logic [maze_pkg::CODE_W-1:0]        mapL;
    logic [maze_pkg::CODE_W-1:0]        mapR;
    logic [maze_pkg::CODE_W-1:0]        mapB;
    logic [maze_pkg::CODE_W-1:0]        mapT;
    logic                               busy;
    logic                               probe_done;

    modport master (
        output frame_clk, restart, BallX, BallY, BallS, rom_data,
        input  rom_addr, mapL, mapR, mapB, mapT, busy, probe_done
    );

    modport slave (
        input  frame_clk, restart, BallX, BallY, BallS, rom_data,
        output rom_addr, mapL, mapR, mapB, mapT, busy, probe_done
    );

endinterface

// File: rtl/tile_addr_calc.sv
// Maps a pixel point to its tile-map ROM address and flags points outside the map.
module tile_addr_calc
    import maze_pkg::*;
(
    input  point_t            pt,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam int unsigned TW = PT_W - TILE_SHIFT;

    logic [TW-1:0] col;
    logic [TW-1:0] row;

    always_comb begin
        col      = pt.px[PT_W-1:TILE_SHIFT];
        row      = pt.py[PT_W-1:TILE_SHIFT];
        in_range = !pt.px[PT_W-1] && !pt.py[PT_W-1] &&
                   (col < TW'(MAP_COLS)) && (row < TW'(MAP_ROWS));
        addr     = ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col);
    end

endmodule

// File: rtl/maze_probe.sv
// Per-frame wall probe: reads the four neighbouring tiles through a 1-cycle ROM
// and publishes all four codes together once the last read has landed.
module maze_probe
    import maze_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    maze_probe_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_RUN    = 2'(RUN);
    localparam logic [1:0] ST_COMMIT = 2'(COMMIT);

    logic fs1_q, fs1_d;
    logic fs2_q, fs2_d;
    logic fs3_q, fs3_d;

    logic [1:0]                          state_q, state_d;
    logic [K_W-1:0]                      k_q, k_d;
    logic [COORD_W-1:0]                  snap_x_q, snap_x_d;
    logic [COORD_W-1:0]                  snap_y_q, snap_y_d;
    logic [COORD_W-1:0]                  snap_s_q, snap_s_d;
    logic [ADDR_W-1:0]                   rom_addr_q, rom_addr_d;
    logic [NUM_PROBES-1:0]               range_q, range_d;
    logic [NUM_PROBES-1:0][CODE_W-1:0]   cap_q, cap_d;
    logic [NUM_PROBES-1:0][CODE_W-1:0]   map_q, map_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;

    logic              start_c;
    point_t            probe_pt_c;
    logic [1:0]        next_slot_c;
    logic [1:0]        cap_slot_c;
    logic [ADDR_W-1:0] calc_addr_c;
    logic              calc_in_range_c;

    // Point for the address issued on the next edge: live inputs when starting, snapshot afterwards
    always_comb begin
        if (state_q == ST_IDLE) begin
            next_slot_c = 2'(PROBE_L);
            probe_pt_c  = probe_point(bus.BallX, bus.BallY, bus.BallS, PROBE_L);
        end else begin
            next_slot_c = 2'(k_q + K_W'(1));
            probe_pt_c  = probe_point(snap_x_q, snap_y_q, snap_s_q, probe_e'(next_slot_c));
        end
    end

    tile_addr_calc u_addr (
        .pt       (probe_pt_c),
        .addr     (calc_addr_c),
        .in_range (calc_in_range_c)
    );

    always_comb begin
        fs1_d      = bus.frame_clk;
        fs2_d      = fs1_q;
        fs3_d      = fs2_q;
        start_c    = fs2_q & ~fs3_q;
        cap_slot_c = 2'(k_q - K_W'(1));

        state_d    = state_q;
        k_d        = k_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_s_d   = snap_s_q;
        rom_addr_d = '0;
        range_d    = range_q;
        cap_d      = cap_q;
        map_d      = map_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d              = ST_RUN;
                    k_d                  = '0;
                    snap_x_d             = bus.BallX;
                    snap_y_d             = bus.BallY;
                    snap_s_d             = bus.BallS;
                    range_d              = '0;
                    range_d[next_slot_c] = calc_in_range_c;
                    rom_addr_d           = calc_in_range_c ? calc_addr_c : '0;
                end
            end
            ST_RUN: begin
                // Data for the address issued last cycle is on rom_data now
                if (k_q != '0) begin
                    cap_d[cap_slot_c] = range_q[cap_slot_c] ? bus.rom_data : TILE_OPEN;
                end
                if (k_q < K_W'(NUM_PROBES - 1)) begin
                    range_d[next_slot_c] = calc_in_range_c;
                    rom_addr_d           = calc_in_range_c ? calc_addr_c : '0;
                end
                if (k_q == K_W'(NUM_PROBES)) begin
                    state_d = ST_COMMIT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_COMMIT: begin
                map_d   = cap_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart wins over start and commit
        if (bus.restart) begin
            state_d    = ST_IDLE;
            k_d        = '0;
            rom_addr_d = '0;
            range_d    = '0;
            cap_d      = '0;
            map_d      = {NUM_PROBES{BLOCKED}};
            done_d     = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1_q      <= 1'b0;
            fs2_q      <= 1'b0;
            fs3_q      <= 1'b0;
            state_q    <= ST_IDLE;
            k_q        <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_s_q   <= '0;
            rom_addr_q <= '0;
            range_q    <= '0;
            cap_q      <= '0;
            map_q      <= {NUM_PROBES{BLOCKED}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fs1_q      <= fs1_d;
            fs2_q      <= fs2_d;
            fs3_q      <= fs3_d;
            state_q    <= state_d;
            k_q        <= k_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_s_q   <= snap_s_d;
            rom_addr_q <= rom_addr_d;
            range_q    <= range_d;
            cap_q      <= cap_d;
            map_q      <= map_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.mapL       = map_q[PROBE_L];
    assign bus.mapR       = map_q[PROBE_R];
    assign bus.mapB       = map_q[PROBE_B];
    assign bus.mapT       = map_q[PROBE_T];
    assign bus.busy       = busy_q;
    assign bus.probe_done = done_q;

endmodule

// File: tb/tb_maze_probe.sv
// Bench for maze_probe: directed scenarios plus random positions against a tile-map model.
module tb_maze_probe;
    import maze_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    maze_probe_if bus ();

    maze_probe dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [4:0] rom_mem [0:1023];
    always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_map [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_maps(input string tag);
        chk($sformatf("%s_mapL", tag), 32'(bus.mapL), 32'(exp_map[0]));
        chk($sformatf("%s_mapR", tag), 32'(bus.mapR), 32'(exp_map[1]));
        chk($sformatf("%s_mapB", tag), 32'(bus.mapB), 32'(exp_map[2]));
        chk($sformatf("%s_mapT", tag), 32'(bus.mapT), 32'(exp_map[3]));
    endtask

    // Tile under a side probe: pixel point -> tile, open if outside the map
    function automatic void model(input int x, input int y, input int s, input int p,
                                  output int addr, output int code);
        int px;
        int py;
        px = x;
        py = y;
        case (p)
            0:       px = x - s - 1;
            1:       px = x + s + 1;
            2:       py = y + s + 1;
            default: py = y - s - 1;
        endcase
        if (px < 0 || py < 0 || (px / 16) >= 26 || (py / 16) >= 28) begin
            addr = 0;
            code = 0;
        end else begin
            addr = (py / 16) * 26 + (px / 16);
            code = int'(rom_mem[addr]);
        end
    endfunction

    // abort_kind: 0 none, 1 restart, 2 reset; applied in busy cycle abort_cyc (k = cyc-1)
    task automatic run_probe(input int x, input int y, input int s,
                             input int abort_kind, input int abort_cyc,
                             input bit retrig, input string tag);
        int ea [4];
        int ec [4];
        int n;
        for (int p = 0; p < 4; p++) model(x, y, s, p, ea[p], ec[p]);
        bus.BallX = 10'(x);
        bus.BallY = 10'(y);
        bus.BallS = 10'(s);
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        n = 0;
        while (!bus.busy && n < 12) begin
            @(negedge Clk);
            n++;
        end
        chk($sformatf("%s_start", tag), 32'(bus.busy), 32'd1);
        if (!bus.busy) begin
            bus.frame_clk = 1'b0;
            return;
        end
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc <= 4)
                chk($sformatf("%s_addr%0d", tag, cyc - 1), 32'(bus.rom_addr), 32'(ea[cyc-1]));
            if (cyc < 7) begin
                chk($sformatf("%s_busy%0d", tag, cyc), 32'(bus.busy), 32'd1);
                chk($sformatf("%s_done%0d", tag, cyc), 32'(bus.probe_done), 32'd0);
                if (cyc == 1 || cyc == 6) check_maps($sformatf("%s_old%0d", tag, cyc));
            end else begin
                chk($sformatf("%s_busy_end", tag), 32'(bus.busy), 32'd0);
                chk($sformatf("%s_done_end", tag), 32'(bus.probe_done), 32'd1);
                for (int p = 0; p < 4; p++) exp_map[p] = 5'(ec[p]);
                check_maps($sformatf("%s_new", tag));
            end
            if (cyc == 1) begin
                bus.BallX = 10'($urandom);
                bus.BallY = 10'($urandom);
                bus.BallS = 10'($urandom);
                if (retrig) bus.frame_clk = 1'b0;
            end
            if (cyc == 2 && retrig) bus.frame_clk = 1'b1;
            if (abort_kind != 0 && cyc == abort_cyc) begin
                if (abort_kind == 1) bus.restart = 1'b1;
                else begin
                    Reset         = 1'b1;
                    bus.frame_clk = 1'b0;
                end
                @(negedge Clk);
                for (int p = 0; p < 4; p++) exp_map[p] = 5'h1F;
                check_maps($sformatf("%s_abort", tag));
                chk($sformatf("%s_abort_busy", tag), 32'(bus.busy), 32'd0);
                chk($sformatf("%s_abort_done", tag), 32'(bus.probe_done), 32'd0);
                chk($sformatf("%s_abort_addr", tag), 32'(bus.rom_addr), 32'd0);
                bus.restart   = 1'b0;
                Reset         = 1'b0;
                bus.frame_clk = 1'b0;
                repeat (4) @(negedge Clk);
                return;
            end
            @(negedge Clk);
        end
        bus.frame_clk = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge Clk);
            if (bus.probe_done) n++;
        end
        chk($sformatf("%s_extra_done", tag), 32'(n), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_clk = 1'b0;
        bus.restart   = 1'b0;
        bus.BallX     = '0;
        bus.BallY     = '0;
        bus.BallS     = '0;
        Reset         = 1'b1;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 5'd0;
        for (int p = 0; p < 4; p++) exp_map[p] = 5'h1F;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_maps("reset");
        chk("reset_addr", 32'(bus.rom_addr), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.probe_done), 32'd0);

        rom_mem[401] = 5'h00;
        rom_mem[403] = 5'h1F;
        rom_mem[428] = 5'h00;
        rom_mem[376] = 5'h03;
        run_probe(202, 253, 13, 0, 0, 1'b0, "centre");
        chk("centre_mapR_const", 32'(bus.mapR), 32'h1F);
        chk("centre_mapT_const", 32'(bus.mapT), 32'h03);

        for (int i = 0; i < 1024; i++) rom_mem[i] = 5'h1F;
        run_probe(10, 200, 13, 0, 0, 1'b0, "left_under");
        chk("left_under_mapL_const", 32'(bus.mapL), 32'd0);
        chk("left_under_mapR_const", 32'(bus.mapR), 32'h1F);

        run_probe(405, 200, 13, 0, 0, 1'b0, "right_over");
        chk("right_over_mapR_const", 32'(bus.mapR), 32'd0);

        for (int i = 0; i < 1024; i++) rom_mem[i] = 5'($urandom);
        run_probe(202, 253, 13, 0, 0, 1'b1, "retrig");
        run_probe(202, 253, 13, 1, 3, 1'b0, "restart_k2");
        run_probe(150, 150, 10, 0, 0, 1'b0, "after_restart");
        run_probe(202, 253, 13, 2, 6, 1'b0, "reset_commit");
        run_probe(300, 100, 8, 0, 0, 1'b0, "after_reset");

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 1024; i++) rom_mem[i] = 5'($urandom);
            run_probe(int'($urandom_range(0, 440)), int'($urandom_range(0, 470)),
                      int'($urandom_range(0, 24)), 0, 0, 1'b0, $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
